// File: rtl/rng_arbiter.sv
// Round-robin arbiter sharing one free-running random-byte source among NREQ
// requesters over a four-phase req/ack handshake, with a post-release cooldown.
module rng_arbiter #(
  parameter int NREQ    = 2,
  parameter int MIN_GAP = 3,
  parameter int CNT_W   = 16,
  localparam int ID_W   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [7:0]           rnd,
  input  logic [NREQ-1:0]      req,
  input  logic [8*NREQ-1:0]    mask,
  output logic [NREQ-1:0]      ack,
  output logic [7:0]           data,
  output logic [ID_W-1:0]      grant_id,
  output logic                 busy,
  output logic [CNT_W-1:0]     draw_count
);

  typedef enum logic [1:0] {S_IDLE, S_ACK, S_GAP} state_t;

  state_t          state;
  logic [ID_W-1:0] last;
  logic [7:0]      gap_cnt;

  logic [ID_W-1:0] win;
  logic [ID_W-1:0] win_hi;
  logic [ID_W-1:0] win_lo;
  logic            found_hi;
  logic            found_lo;
  logic [NREQ-1:0] win_onehot;
  logic [7:0]      win_mask;
  logic            owner_req;

  // Round-robin: first requester above `last`, otherwise wrap to the lowest one.
  always_comb begin
    win_hi   = '0;
    win_lo   = '0;
    found_hi = 1'b0;
    found_lo = 1'b0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (req[i]) begin
        if (!found_hi && (ID_W'(i) > last)) begin
          found_hi = 1'b1;
          win_hi   = ID_W'(i);
        end
        if (!found_lo) begin
          found_lo = 1'b1;
          win_lo   = ID_W'(i);
        end
      end
    end
    win = found_hi ? win_hi : win_lo;
  end

  always_comb begin
    win_onehot = '0;
    win_mask   = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (ID_W'(i) == win) begin
        win_onehot[i] = 1'b1;
        win_mask      = mask[8*i +: 8];
      end
    end
  end

  // ack is one-hot on the owner, so this is the owner's current request level.
  assign owner_req = |(req & ack);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= S_IDLE;
      ack        <= '0;
      data       <= '0;
      grant_id   <= '0;
      busy       <= 1'b0;
      draw_count <= '0;
      gap_cnt    <= '0;
      last       <= ID_W'(NREQ - 1);
    end else begin
      case (state)
        S_IDLE: begin
          if (|req) begin
            ack        <= win_onehot;
            data       <= rnd & win_mask;
            grant_id   <= win;
            last       <= win;
            draw_count <= draw_count + CNT_W'(1);
            busy       <= 1'b1;
            state      <= S_ACK;
          end
        end
        S_ACK: begin
          if (!owner_req) begin
            ack <= '0;
            if (MIN_GAP == 0) begin
              busy  <= 1'b0;
              state <= S_IDLE;
            end else begin
              gap_cnt <= 8'(MIN_GAP);
              state   <= S_GAP;
            end
          end
        end
        S_GAP: begin
          gap_cnt <= gap_cnt - 8'd1;
          if (gap_cnt == 8'd1) begin
            busy  <= 1'b0;
            state <= S_IDLE;
          end
        end
        default: begin
          busy  <= 1'b0;
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rng_arbiter.sv
// Bench for rng_arbiter: directed handshake/cooldown/reset/wrap cases plus a
// randomized run checked each cycle against a transaction-level model.
module tb_rng_arbiter;

  localparam int NA = 3;
  localparam int GA = 3;
  localparam int CA = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  rnd;

  logic [NA-1:0]   req_a;
  logic [8*NA-1:0] mask_a;
  logic [NA-1:0]   ack_a;
  logic [7:0]      data_a;
  logic [1:0]      gid_a;
  logic            busy_a;
  logic [CA-1:0]   cnt_a;

  logic [1:0]  req_b;
  logic [15:0] mask_b;
  logic [1:0]  ack_b;
  logic [7:0]  data_b;
  logic [0:0]  gid_b;
  logic        busy_b;
  logic [15:0] cnt_b;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  rng_arbiter #(.NREQ(NA), .MIN_GAP(GA), .CNT_W(CA)) dut_a (
    .clk(clk), .rst(rst), .rnd(rnd), .req(req_a), .mask(mask_a),
    .ack(ack_a), .data(data_a), .grant_id(gid_a), .busy(busy_a),
    .draw_count(cnt_a)
  );

  rng_arbiter #(.NREQ(2), .MIN_GAP(0), .CNT_W(16)) dut_b (
    .clk(clk), .rst(rst), .rnd(rnd), .req(req_b), .mask(mask_b),
    .ack(ack_b), .data(data_b), .grant_id(gid_b), .busy(busy_b),
    .draw_count(cnt_b)
  );

  always #5 clk = ~clk;

  initial begin
    #1ms;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Model for dut_a: owner of the bus (-1 none), idle edges still to wait.
  int         m_owner, m_cool, m_last, m_gid, m_cnt;
  logic [7:0] m_data;

  function automatic void model_reset();
    m_owner = -1;
    m_cool  = 0;
    m_last  = NA - 1;
    m_gid   = 0;
    m_cnt   = 0;
    m_data  = 8'h00;
  endfunction

  function automatic void model_step();
    int w;
    if (m_owner >= 0) begin
      if (!req_a[m_owner]) begin
        m_owner = -1;
        m_cool  = GA;
      end
    end else if (m_cool > 0) begin
      m_cool--;
    end else if (req_a != '0) begin
      w = -1;
      for (int k = 1; k <= NA; k++) begin
        if (w < 0 && req_a[(m_last + k) % NA]) w = (m_last + k) % NA;
      end
      m_owner = w;
      m_last  = w;
      m_gid   = w;
      m_data  = rnd & mask_a[8*w +: 8];
      m_cnt   = (m_cnt + 1) % (1 << CA);
    end
  endfunction

  task automatic tick();
    logic [NA-1:0] e_ack;
    @(posedge clk);
    model_step();
    cyc++;
    #1;
    e_ack = (m_owner >= 0) ? NA'(1 << m_owner) : '0;
    check("ack",   32'(ack_a),  32'(e_ack));
    check("data",  32'(data_a), 32'(m_data));
    check("gid",   32'(gid_a),  32'(m_gid));
    check("busy",  32'(busy_a), 32'((m_owner >= 0) || (m_cool > 0)));
    check("count", 32'(cnt_a),  32'(m_cnt));
    @(negedge clk);
    rnd = 8'($urandom);
  endtask

  task automatic wait_grant_a();
    int n = 0;
    while (ack_a == '0 && n < 40) begin
      tick();
      n++;
    end
    check("grant_wait", 32'(ack_a != '0), 32'd1);
  endtask

  task automatic idle_a();
    int n = 0;
    while (busy_a && n < 40) begin
      tick();
      n++;
    end
    check("idle_wait", 32'(busy_a), 32'd0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    #1;
    model_reset();
    check("rst_ack",   32'(ack_a),  32'd0);
    check("rst_data",  32'(data_a), 32'd0);
    check("rst_gid",   32'(gid_a),  32'd0);
    check("rst_busy",  32'(busy_a), 32'd0);
    check("rst_count", 32'(cnt_a),  32'd0);
    check("rst_ack_b", 32'(ack_b),  32'd0);
    check("rst_cnt_b", 32'(cnt_b),  32'd0);
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    logic [7:0] d_hold;
    logic [7:0] r_pre;
    logic [NA-1:0] pa;
    logic [1:0] pb;
    bit   held [NA];
    int   hold [NA];
    int   rises, last_c, pg;

    rst = 1'b0; rnd = 8'h00;
    req_a = '0; mask_a = '0; req_b = '0; mask_b = '0;
    model_reset();
    do_reset();

    // Single request after reset
    rnd = 8'hA5; mask_a = 24'h00000F; req_a = 3'b001;
    tick();
    check("t1_ack",   32'(ack_a),  32'h1);
    check("t1_data",  32'(data_a), 32'h05);
    check("t1_gid",   32'(gid_a),  32'd0);
    check("t1_count", 32'(cnt_a),  32'd1);
    check("t1_busy",  32'(busy_a), 32'd1);

    // Release then reassert at once: no grant during the three GAP edges
    req_a = 3'b000;
    tick();
    check("rel_ack", 32'(ack_a), 32'd0);
    req_a = 3'b001;
    for (int i = 0; i < GA; i++) begin
      tick();
      check("gap_noack", 32'(ack_a), 32'd0);
    end
    tick();
    check("gap_then_grant", 32'(ack_a), 32'h1);
    req_a = '0;
    tick();
    idle_a();

    // Handshake hold on requester 1 while rnd keeps changing
    mask_a = 24'($urandom);
    req_a = 3'b010;
    wait_grant_a();
    check("hold_first", 32'(ack_a), 32'h2);
    d_hold = data_a;
    for (int i = 0; i < 10; i++) begin
      tick();
      check("hold_ack",  32'(ack_a),  32'h2);
      check("hold_data", 32'(data_a), 32'(d_hold));
    end
    req_a = '0;
    tick();
    check("hold_drop", 32'(ack_a), 32'd0);
    idle_a();

    // Fairness: requesters 0 and 1 drop one cycle after seeing ack
    held[0] = 0; held[1] = 0;
    rises = 0; last_c = 0; pg = 0;
    for (int n = 0; n < 100 && rises < 8; n++) begin
      for (int i = 0; i < 2; i++) begin
        if (ack_a[i]) begin
          if (held[i]) req_a[i] = 1'b0;
          held[i] = 1;
        end else begin
          held[i] = 0;
          req_a[i] = 1'b1;
        end
      end
      pa = ack_a;
      tick();
      if (ack_a != '0 && pa == '0) begin
        if (rises > 0) begin
          check("rr_alt",    32'(gid_a),       32'(pg ^ 1));
          check("rr_period", 32'(cyc - last_c), 32'd6);
        end
        pg = int'(gid_a);
        last_c = cyc;
        rises++;
      end
    end
    check("rr_rises", 32'(rises), 32'd8);
    req_a = '0;
    tick();
    idle_a();

    // Async reset in the middle of an ACK on requester 1
    req_a = 3'b010;
    wait_grant_a();
    tick();
    check("pre_rst_ack", 32'(ack_a), 32'h2);
    do_reset();
    req_a = 3'b011; mask_a = 24'($urandom);
    tick();
    check("post_rst_winner", 32'(ack_a), 32'h1);
    req_a = '0;
    tick();
    idle_a();

    // Counter wrap (4 bits) and a zero mask that still counts
    do_reset();
    for (int g = 0; g < 17; g++) begin
      mask_a[7:0] = (g == 5) ? 8'h00 : 8'($urandom);
      req_a = 3'b001;
      wait_grant_a();
      if (g == 5) check("mask0_data", 32'(data_a), 32'd0);
      req_a = '0;
      tick();
    end
    check("wrap_count", 32'(cnt_a), 32'd1);
    idle_a();

    // MIN_GAP = 0 instance: grant every 3 cycles with one-cycle-late release
    mask_b = 16'($urandom);
    held[0] = 0; rises = 0; last_c = 0;
    for (int n = 0; n < 60 && rises < 6; n++) begin
      if (ack_b[0]) begin
        if (held[0]) req_b[0] = 1'b0;
        held[0] = 1;
      end else begin
        held[0] = 0;
        req_b[0] = 1'b1;
      end
      pb = ack_b;
      r_pre = rnd;
      tick();
      if (ack_b != '0 && pb == '0) begin
        check("b_ack",  32'(ack_b),  32'h1);
        check("b_data", 32'(data_b), 32'(r_pre & mask_b[7:0]));
        if (rises > 0) check("b_period", 32'(cyc - last_c), 32'd3);
        last_c = cyc;
        rises++;
      end
    end
    check("b_rises", 32'(rises), 32'd6);
    req_b = '0;

    // Randomized traffic, including abandoned request pulses
    for (int i = 0; i < NA; i++) hold[i] = 0;
    for (int n = 0; n < 3000; n++) begin
      if (n % 8 == 0) mask_a = 24'($urandom);
      for (int i = 0; i < NA; i++) begin
        if (req_a[i]) begin
          if (ack_a[i]) begin
            if (hold[i] == 0) req_a[i] = 1'b0;
            else hold[i]--;
          end else if ($urandom_range(0, 15) == 0) begin
            req_a[i] = 1'b0;
          end
        end else if ($urandom_range(0, 2) == 0) begin
          req_a[i] = 1'b1;
          hold[i] = int'($urandom_range(0, 3));
        end
      end
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/rng_arbiter.md
# rng_arbiter

Shares one free-running random-byte generator between several requesters (CPU CXNN execution unit, display/sound test logic, debug port) using round-robin arbitration and a four-phase req/ack handshake. Each grant samples the generator, applies the requester's mask (CXNN semantics: `rnd & NN`), and returns the byte on a shared data bus. A programmable cooldown between grants ensures successive delivered bytes are separated by several generator steps.

## Interface
- `NREQ`, default 2, number of requesters (1..8).
- `MIN_GAP`, default 3, idle cycles enforced after each ack release before the next grant (0..255).
- `CNT_W`, default 16, width of the draw counter.

- `clk` in 1: clock.
- `rst` in 1: reset, asynchronous, active-high.
- `rnd` in 8: current generator byte; changes every `clk`.
- `req` in NREQ: per-requester request level.
- `mask` in 8*NREQ: per-requester mask; requester i uses bits [8i+7:8i].
- `ack` out NREQ: per-requester acknowledge level (one-hot or zero).
- `data` out 8: masked random byte; valid while any `ack` is high.
- `grant_id` out clog2(NREQ), min 1: index of the current/last granted requester.
- `busy` out 1: high in ACK and GAP states.
- `draw_count` out CNT_W: number of grants since reset, wrapping.

## Operation
- States: IDLE, ACK, GAP.
- IDLE: if any `req` bit is high, select winner by round-robin: search starts at `(last + 1) mod NREQ`, wrapping; `last` is the previously granted index. Reset value of `last` is NREQ-1, so requester 0 wins first.
- Grant edge (IDLE, any req): `ack[w]` <= 1, `data` <= `rnd & mask[w]` (values sampled at this edge), `grant_id` <= w, `last` <= w, `draw_count` += 1 (wraps to 0), state -> ACK.
- ACK: `ack[w]`, `data`, `grant_id` held stable. Other requests are ignored. When `req[w]` is sampled low: `ack` <= 0, gap counter <= MIN_GAP, state -> GAP (or -> IDLE directly if MIN_GAP = 0).
- GAP: counter decrements each edge; on the edge where counter = 1, state -> IDLE. No grants in GAP.
- `data` keeps its last value after ack drops (not cleared); `grant_id` likewise.
- Requesters hold `req` high until `ack` is seen. A `req` pulse that drops before a grant edge is never served. A requester may reassert immediately after ack drops; it is served in round-robin order after GAP.
- A mask of 0x00 still produces a grant (data 0x00) and increments `draw_count`.
- `busy` = (state != IDLE).

## Timing
- Reset (async, immediate): state IDLE, `ack` = 0, `data` = 0x00, `grant_id` = 0, `busy` = 0, `draw_count` = 0, gap counter = 0, `last` = NREQ-1. Reset during ACK or GAP aborts with no further ack.
- Latency: `req` sampled high at edge N in IDLE -> `ack` high after edge N (1 cycle); `data` equals `rnd` present before edge N, masked.
- Release: `req[w]` sampled low at edge M -> `ack` low after edge M.
- Next grant edge no earlier than M + MIN_GAP + 1 (M + 1 when MIN_GAP = 0).
- Simultaneous requests at one grant edge: exactly one `ack` bit, chosen by round-robin; others wait.
- Throughput with continuous requests and instant release: one grant per MIN_GAP + 3 cycles.

## Test plan
- Reset then single request: `rnd` = 0xA5, `mask[0]` = 0x0F, `req` = 01 at edge N -> `ack` = 01 after N, `data` = 0x05, `grant_id` = 0, `draw_count` = 1, `busy` = 1.
- Round-robin fairness: NREQ = 2, both `req` held high and released one cycle after each ack -> grants alternate 0,1,0,1; each new ack exactly MIN_GAP + 3 = 6 cycles after the previous ack rise.
- Handshake hold: hold `req[1]` high 10 cycles after ack while `rnd` changes each cycle -> `ack[1]` and `data` constant for all 10 cycles; `ack` drops one edge after `req[1]` falls.
- Cooldown with MIN_GAP = 0: single requester reasserting immediately -> grant every 3 cycles; with MIN_GAP = 3 -> no grant during the 3 GAP cycles even with `req` high.
- Async reset mid-ACK: assert `rst` between edges while `ack` = 10 -> `ack` = 0, `data` = 0x00, `draw_count` = 0, `busy` = 0 immediately; after release, requester 0 wins first.
- Counter wrap with CNT_W = 4: 17 grants -> `draw_count` reads 1; mask 0x00 grant returns `data` 0x00 and still counts.
